// File: rtl/uart_rx_frame_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_frame_ctrl
//
// Frame controller placed behind a UART byte receiver. It enables the
// receiver, parses frames of the form SOF, LEN, payload[LEN], checksum,
// buffers the payload and, once the checksum matches, streams the payload
// downstream over a valid/ready interface. Malformed, corrupted or aborted
// frames are dropped and reported through frame_err / err_code.
//
// Checksum: chk = LEN ^ payload[0] ^ ... ^ payload[LEN-1].
//
// Optional feature macro: UART_FRAME_TIMEOUT_EN
//   defined   - inter-byte timer; TIMEOUT_CYC idle cycles inside a frame
//               raise err_code 0 (TIMEOUT) and return to WAIT_SOF.
//   undefined - no timer, err_code 0 is never produced.
//
// Parameters:
//   MAX_LEN     payload buffer depth in bytes (1..255)
//   SOF         start-of-frame byte
//   TIMEOUT_CYC max clk cycles between rx_done pulses inside a frame (>= 2)
//
// Ports:
//   clk        in   system clock
//   arst_n     in   asynchronous active-low reset
//   en         in   controller enable
//   rx_done    in   one-cycle byte-valid pulse from the receiver
//   rx_err     in   one-cycle framing-error pulse from the receiver
//   rx_data    in   received byte, valid with rx_done
//   rx_en      out  receiver enable
//   out_data   out  payload byte
//   out_valid  out  out_data is valid
//   out_ready  in   downstream accepts the byte
//   out_last   out  current byte is the final payload byte
//   busy       out  frame in progress or draining
//   frame_err  out  one-cycle error pulse
//   err_code   out  cause of the latest error (0 TIMEOUT, 1 LEN, 2 CHK, 3 UART)
//   frame_cnt  out  good-frame counter, wraps modulo 2^16
// -----------------------------------------------------------------------------
module uart_rx_frame_ctrl #(
    parameter int         MAX_LEN     = 16,
    parameter logic [7:0] SOF         = 8'hA5,
    parameter int         TIMEOUT_CYC = 208320
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        en,
    input  logic        rx_done,
    input  logic        rx_err,
    input  logic [7:0]  rx_data,
    output logic        rx_en,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic        busy,
    output logic        frame_err,
    output logic [1:0]  err_code,
    output logic [15:0] frame_cnt
);

    localparam int         AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    localparam logic [1:0] ERR_TIMEOUT = 2'd0;
    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_CHK     = 2'd2;
    localparam logic [1:0] ERR_UART    = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_SOF = 3'd1,
        S_LEN      = 3'd2,
        S_PAYLOAD  = 3'd3,
        S_CHK      = 3'd4,
        S_DRAIN    = 3'd5
    } state_t;

    state_t      r_state;
    logic        r_rx_en;
    logic        r_out_valid;
    logic        r_busy;
    logic        r_frame_err;
    logic [1:0]  r_err_code;
    logic [15:0] r_frame_cnt;
    logic [7:0]  r_len;
    logic [7:0]  r_wr_ptr;
    logic [7:0]  r_rd_ptr;
    logic [7:0]  r_chk;
    logic [7:0]  r_buf [MAX_LEN];

    logic        w_in_frame;
    logic        w_byte_ok;
    logic        w_buf_we;
    logic        w_timeout;
    logic        w_err;
    logic [1:0]  w_err_code;

    // States in which an error or an abort on en low can end the frame.
    assign w_in_frame = (r_state == S_LEN) || (r_state == S_PAYLOAD) || (r_state == S_CHK);
    // A byte that arrives together with rx_err is discarded.
    assign w_byte_ok  = rx_done & ~rx_err;
    assign w_buf_we   = (r_state == S_PAYLOAD) & en & w_byte_ok;

`ifdef UART_FRAME_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] r_to_cnt;

    // Inter-byte timer: holds 0 the cycle after each rx_done (and on LEN
    // entry, which is itself an rx_done), then counts while inside a frame.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_to_cnt <= '0;
        end else if (!w_in_frame || rx_done) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + TW'(1);
        end
    end

    // The counter is TIMEOUT_CYC-2 one cycle before the limit; the registered
    // error pulse then lands exactly TIMEOUT_CYC cycles after the last rx_done.
    assign w_timeout = w_in_frame & ~rx_done & (r_to_cnt == TW'(TIMEOUT_CYC - 2));
`else
    // No inter-byte timer in this build; evaluates to 0 for any legal TIMEOUT_CYC.
    assign w_timeout = (TIMEOUT_CYC < 0);
`endif

    // Error detection and cause, in priority order UART > TIMEOUT > LEN > CHK.
    always_comb begin
        w_err      = 1'b0;
        w_err_code = ERR_UART;
        if (w_in_frame) begin
            if (rx_err) begin
                w_err      = 1'b1;
                w_err_code = ERR_UART;
            end else if (w_timeout) begin
                w_err      = 1'b1;
                w_err_code = ERR_TIMEOUT;
            end else if (rx_done && (r_state == S_LEN) &&
                         ((rx_data == 8'h00) || (rx_data > MAX_LEN_B))) begin
                w_err      = 1'b1;
                w_err_code = ERR_LEN;
            end else if (rx_done && (r_state == S_CHK) && (rx_data != r_chk)) begin
                w_err      = 1'b1;
                w_err_code = ERR_CHK;
            end else begin
                w_err      = 1'b0;
                w_err_code = ERR_UART;
            end
        end else begin
            w_err      = 1'b0;
            w_err_code = ERR_UART;
        end
    end

    // Frame FSM with all registered outputs and frame bookkeeping.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state     <= S_IDLE;
            r_rx_en     <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_frame_err <= 1'b0;
            r_err_code  <= 2'd0;
            r_frame_cnt <= 16'd0;
            r_len       <= 8'd0;
            r_wr_ptr    <= 8'd0;
            r_rd_ptr    <= 8'd0;
            r_chk       <= 8'd0;
        end else begin
            r_frame_err <= 1'b0;
            if (w_in_frame && !en) begin
                // Abort without reporting; the partial frame is dropped.
                r_state <= S_IDLE;
                r_rx_en <= 1'b0;
                r_busy  <= 1'b0;
            end else if (w_err) begin
                r_state     <= S_WAIT_SOF;
                r_busy      <= 1'b0;
                r_frame_err <= 1'b1;
                r_err_code  <= w_err_code;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (en) begin
                            r_state <= S_WAIT_SOF;
                            r_rx_en <= 1'b1;
                        end else begin
                            r_rx_en <= 1'b0;
                        end
                    end
                    S_WAIT_SOF: begin
                        if (!en) begin
                            r_state <= S_IDLE;
                            r_rx_en <= 1'b0;
                        end else if (w_byte_ok && (rx_data == SOF)) begin
                            r_state <= S_LEN;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= S_WAIT_SOF;
                        end
                    end
                    S_LEN: begin
                        // rx_err and illegal lengths were caught above.
                        if (rx_done) begin
                            r_len    <= rx_data;
                            r_chk    <= rx_data;
                            r_wr_ptr <= 8'd0;
                            r_state  <= S_PAYLOAD;
                        end else begin
                            r_state <= S_LEN;
                        end
                    end
                    S_PAYLOAD: begin
                        if (rx_done) begin
                            r_chk    <= r_chk ^ rx_data;
                            r_wr_ptr <= r_wr_ptr + 8'd1;
                            if (r_wr_ptr == (r_len - 8'd1)) begin
                                r_state <= S_CHK;
                            end else begin
                                r_state <= S_PAYLOAD;
                            end
                        end else begin
                            r_state <= S_PAYLOAD;
                        end
                    end
                    S_CHK: begin
                        // A mismatching checksum was caught above.
                        if (rx_done) begin
                            r_state     <= S_DRAIN;
                            r_rx_en     <= 1'b0;
                            r_out_valid <= 1'b1;
                            r_rd_ptr    <= 8'd0;
                            r_frame_cnt <= r_frame_cnt + 16'd1;
                        end else begin
                            r_state <= S_CHK;
                        end
                    end
                    S_DRAIN: begin
                        // en is only honoured once the whole frame is delivered.
                        if (r_out_valid && out_ready) begin
                            if (r_rd_ptr == (r_len - 8'd1)) begin
                                r_out_valid <= 1'b0;
                                r_busy      <= 1'b0;
                                if (en) begin
                                    r_state <= S_WAIT_SOF;
                                    r_rx_en <= 1'b1;
                                end else begin
                                    r_state <= S_IDLE;
                                    r_rx_en <= 1'b0;
                                end
                            end else begin
                                r_rd_ptr <= r_rd_ptr + 8'd1;
                            end
                        end else begin
                            r_state <= S_DRAIN;
                        end
                    end
                    default: begin
                        r_state     <= S_IDLE;
                        r_rx_en     <= 1'b0;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Payload buffer write port.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                r_buf[i] <= 8'h00;
            end
        end else if (w_buf_we) begin
            r_buf[r_wr_ptr[AW-1:0]] <= rx_data;
        end
    end

    // Read-side decode; forced to 0 outside DRAIN so reset values are 0.
    always_comb begin
        out_data = 8'h00;
        out_last = 1'b0;
        if (r_out_valid) begin
            out_data = r_buf[r_rd_ptr[AW-1:0]];
            out_last = (r_rd_ptr == (r_len - 8'd1));
        end else begin
            out_data = 8'h00;
            out_last = 1'b0;
        end
    end

    assign rx_en     = r_rx_en;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign frame_err = r_frame_err;
    assign err_code  = r_err_code;
    assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_frame_ctrl
//
// Self-checking bench for uart_rx_frame_ctrl (default build, no timeout).
// Directed cycle-by-cycle vectors, hand-written multi-cycle sequences, and a
// randomized frame stream checked against a frame-level model (queues of
// expected payload bytes and expected error codes).
// -----------------------------------------------------------------------------
module tb_uart_rx_frame_ctrl;

    localparam int MAXL = 16;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic        en = 1'b0;
    logic        rx_done = 1'b0;
    logic        rx_err = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_en;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_last;
    logic        busy;
    logic        frame_err;
    logic [1:0]  err_code;
    logic [15:0] frame_cnt;

    int checks = 0;
    int failures = 0;

    logic        mon_en = 1'b0;
    logic        rand_ready = 1'b0;
    int          gap_max = 2;
    logic [15:0] exp_fc = 16'd0;
    logic [8:0]  exp_q[$];      // {last, byte}
    logic [1:0]  err_q[$];

    uart_rx_frame_ctrl #(.MAX_LEN(MAXL), .SOF(8'hA5), .TIMEOUT_CYC(208320)) dut (
        .clk(clk), .arst_n(arst_n), .en(en), .rx_done(rx_done), .rx_err(rx_err),
        .rx_data(rx_data), .rx_en(rx_en), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .busy(busy), .frame_err(frame_err),
        .err_code(err_code), .frame_cnt(frame_cnt)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [30:0] outs();
        return {rx_en, out_valid, out_data, out_last, busy, frame_err, err_code, frame_cnt};
    endfunction

    // One clock; optionally randomizes out_ready and checks handshakes/errors.
    task automatic step();
        logic       hs;
        logic       hold;
        logic [7:0] d;
        logic [8:0] e;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        hs   = out_valid && out_ready;
        hold = out_valid && !out_ready;
        d    = out_data;
        if (mon_en && hs) begin
            check("out_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("out_byte", {23'd0, out_last, out_data}, {23'd0, e});
            end
        end
        @(posedge clk);
        #1;
        if (mon_en) begin
            if (hold) check("hold_stable", {23'd0, out_valid, out_data}, {23'd0, 1'b1, d});
            if (frame_err) begin
                check("err_expected", 32'(err_q.size() != 0), 32'd1);
                if (err_q.size() != 0) check("err_code", 32'(err_code), 32'(err_q.pop_front()));
            end
        end
    endtask

    // Deliver one receiver event once rx_en is high, then idle a few cycles.
    task automatic send(input logic [7:0] b, input logic d, input logic e);
        int n;
        n = 0;
        while (!rx_en && n < 300) begin
            step();
            n++;
        end
        if (!rx_en) check("rx_en_wait", 32'(rx_en), 32'd1);
        rx_done = d;
        rx_err  = e;
        rx_data = b;
        step();
        rx_done = 1'b0;
        rx_err  = 1'b0;
        rx_data = 8'($urandom_range(0, 255));
        repeat ($urandom_range(0, gap_max)) step();
    endtask

    typedef struct {
        logic        en;
        logic        done;
        logic        err;
        logic [7:0]  data;
        logic        rdy;
        logic [30:0] exp;
    } vec_t;
    vec_t vq[$];

    task automatic add(input logic i_en, input logic i_d, input logic i_e, input logic [7:0] i_b,
                       input logic i_r, input logic x_rx, input logic x_v, input logic [7:0] x_d,
                       input logic x_l, input logic x_b, input logic x_f, input logic [1:0] x_c,
                       input logic [15:0] x_fc);
        vec_t v;
        v.en = i_en; v.done = i_d; v.err = i_e; v.data = i_b; v.rdy = i_r;
        v.exp = {x_rx, x_v, x_d, x_l, x_b, x_f, x_c, x_fc};
        vq.push_back(v);
    endtask

    initial begin
        logic [7:0] bp_bytes [4];
        logic [7:0] pay [$];
        logic [7:0] b;
        logic [7:0] c;
        logic [7:0] ln;
        logic [7:0] prev;
        int         nhs;
        int         n;
        int         kind;
        int         m;

        // ---------------- reset values ----------------
        #12;
        check("reset_outputs", {1'b0, outs()}, 32'd0);
        arst_n = 1'b1;
        step();
        check("idle_after_reset", {1'b0, outs()}, 32'd0);

        // ---------------- directed vector table ----------------
        //   en d  e  data   rdy | rx_en v data last busy ferr code fc
        add(1, 0, 0, 8'h00, 0,   1, 0, 8'h00, 0, 0, 0, 2'd0, 16'd0);
        add(1, 1, 0, 8'hA5, 0,   1, 0, 8'h00, 0, 1, 0, 2'd0, 16'd0);
        add(1, 1, 0, 8'h03, 0,   1, 0, 8'h00, 0, 1, 0, 2'd0, 16'd0);
        add(1, 1, 0, 8'h11, 0,   1, 0, 8'h00, 0, 1, 0, 2'd0, 16'd0);
        add(1, 1, 0, 8'h22, 0,   1, 0, 8'h00, 0, 1, 0, 2'd0, 16'd0);
        add(1, 1, 0, 8'h33, 0,   1, 0, 8'h00, 0, 1, 0, 2'd0, 16'd0);
        add(1, 1, 0, 8'h03, 1,   0, 1, 8'h11, 0, 1, 0, 2'd0, 16'd1);
        add(1, 1, 0, 8'hA5, 1,   0, 1, 8'h22, 0, 1, 0, 2'd0, 16'd1); // byte lost in drain
        add(1, 0, 0, 8'h00, 1,   0, 1, 8'h33, 1, 1, 0, 2'd0, 16'd1);
        add(1, 0, 0, 8'h00, 1,   1, 0, 8'h00, 0, 0, 0, 2'd0, 16'd1);
        // bad checksum A5 02 10 20 00 (correct would be 32)
        add(1, 1, 0, 8'hA5, 0,   1, 0, 8'h00, 0, 1, 0, 2'd0, 16'd1);
        add(1, 1, 0, 8'h02, 0,   1, 0, 8'h00, 0, 1, 0, 2'd0, 16'd1);
        add(1, 1, 0, 8'h10, 0,   1, 0, 8'h00, 0, 1, 0, 2'd0, 16'd1);
        add(1, 1, 0, 8'h20, 0,   1, 0, 8'h00, 0, 1, 0, 2'd0, 16'd1);
        add(1, 1, 0, 8'h00, 0,   1, 0, 8'h00, 0, 0, 1, 2'd2, 16'd1);
        add(1, 0, 0, 8'h00, 0,   1, 0, 8'h00, 0, 0, 0, 2'd2, 16'd1);
        // bad length: 0, then MAX_LEN+1
        add(1, 1, 0, 8'hA5, 0,   1, 0, 8'h00, 0, 1, 0, 2'd2, 16'd1);
        add(1, 1, 0, 8'h00, 0,   1, 0, 8'h00, 0, 0, 1, 2'd1, 16'd1);
        add(1, 1, 0, 8'hA5, 0,   1, 0, 8'h00, 0, 1, 0, 2'd1, 16'd1);
        add(1, 1, 0, 8'h11, 0,   1, 0, 8'h00, 0, 0, 1, 2'd1, 16'd1);
        add(1, 0, 0, 8'h00, 0,   1, 0, 8'h00, 0, 0, 0, 2'd1, 16'd1);
        // rx_done together with rx_err in LEN
        add(1, 1, 0, 8'hA5, 0,   1, 0, 8'h00, 0, 1, 0, 2'd1, 16'd1);
        add(1, 1, 1, 8'h03, 0,   1, 0, 8'h00, 0, 0, 1, 2'd3, 16'd1);
        add(1, 0, 0, 8'h00, 0,   1, 0, 8'h00, 0, 0, 0, 2'd3, 16'd1);
        add(1, 1, 0, 8'hA5, 0,   1, 0, 8'h00, 0, 1, 0, 2'd3, 16'd1);
        add(1, 1, 0, 8'h00, 0,   1, 0, 8'h00, 0, 0, 1, 2'd1, 16'd1);
        // rx_err mid-payload
        add(1, 1, 0, 8'hA5, 0,   1, 0, 8'h00, 0, 1, 0, 2'd1, 16'd1);
        add(1, 1, 0, 8'h02, 0,   1, 0, 8'h00, 0, 1, 0, 2'd1, 16'd1);
        add(1, 1, 0, 8'h11, 0,   1, 0, 8'h00, 0, 1, 0, 2'd1, 16'd1);
        add(1, 0, 1, 8'h00, 0,   1, 0, 8'h00, 0, 0, 1, 2'd3, 16'd1);
        add(1, 0, 0, 8'h00, 0,   1, 0, 8'h00, 0, 0, 0, 2'd3, 16'd1);
        // en low mid-frame: silent abort to IDLE
        add(1, 1, 0, 8'hA5, 0,   1, 0, 8'h00, 0, 1, 0, 2'd3, 16'd1);
        add(0, 0, 0, 8'h00, 0,   0, 0, 8'h00, 0, 0, 0, 2'd3, 16'd1);
        add(0, 0, 0, 8'h00, 0,   0, 0, 8'h00, 0, 0, 0, 2'd3, 16'd1);
        add(1, 0, 0, 8'h00, 0,   1, 0, 8'h00, 0, 0, 0, 2'd3, 16'd1);
        // noise in WAIT_SOF is ignored
        add(1, 1, 0, 8'h5A, 0,   1, 0, 8'h00, 0, 0, 0, 2'd3, 16'd1);
        add(1, 0, 1, 8'h00, 0,   1, 0, 8'h00, 0, 0, 0, 2'd3, 16'd1);
        add(1, 1, 1, 8'hA5, 0,   1, 0, 8'h00, 0, 0, 0, 2'd3, 16'd1);

        for (int i = 0; i < vq.size(); i++) begin
            en = vq[i].en; rx_done = vq[i].done; rx_err = vq[i].err;
            rx_data = vq[i].data; out_ready = vq[i].rdy;
            step();
            check($sformatf("vec%0d", i), {1'b0, outs()}, {1'b0, vq[i].exp});
        end
        rx_done = 1'b0; rx_err = 1'b0; out_ready = 1'b0;
        exp_fc = 16'd1;

        // ---------------- backpressure: A5 04 01 02 03 04 chk 00 ----------------
        bp_bytes[0] = 8'h01; bp_bytes[1] = 8'h02; bp_bytes[2] = 8'h03; bp_bytes[3] = 8'h04;
        send(8'hA5, 1, 0); send(8'h04, 1, 0);
        for (int i = 0; i < 4; i++) send(bp_bytes[i], 1, 0);
        send(8'h00, 1, 0);
        exp_fc++;
        nhs = 0;
        n = 0;
        while (out_valid && n < 40) begin
            out_ready = n[0];
            prev = out_data;
            if (out_ready) begin
                check("bp_byte", {23'd0, out_last, out_data},
                      {23'd0, (nhs == 3), bp_bytes[nhs & 3]});
                nhs++;
                step();
            end else begin
                step();
                check("bp_hold", {23'd0, out_valid, out_data}, {23'd0, 1'b1, prev});
            end
            n++;
        end
        check("bp_handshakes", 32'(nhs), 32'd4);
        check("bp_frame_cnt", 32'(frame_cnt), 32'(exp_fc));
        out_ready = 1'b0;

        // ---------------- en dropped during DRAIN: A5 02 AA BB chk 13 ----------------
        send(8'hA5, 1, 0); send(8'h02, 1, 0); send(8'hAA, 1, 0); send(8'hBB, 1, 0);
        send(8'h13, 1, 0);
        exp_fc++;
        check("drain_first", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'hAA});
        en = 1'b0;
        out_ready = 1'b1;
        step();
        check("drain_last", {22'd0, out_valid, out_last, out_data}, {22'd0, 1'b1, 1'b1, 8'hBB});
        step();
        check("drain_end", {29'd0, rx_en, busy, out_valid}, 32'd0);
        step();
        check("drain_idle", {31'd0, rx_en}, 32'd0);
        en = 1'b1;
        step();
        check("idle_to_wait", {30'd0, rx_en, busy}, 32'd2);
        check("drain_frame_cnt", 32'(frame_cnt), 32'(exp_fc));
        out_ready = 1'b0;

        // ---------------- asynchronous reset mid-PAYLOAD ----------------
        send(8'hA5, 1, 0); send(8'h03, 1, 0); send(8'h11, 1, 0);
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        #2;
        arst_n = 1'b0;
        #1;
        check("async_rst_outputs", {1'b0, outs()}, 32'd0);
        #1;
        arst_n = 1'b1;
        exp_fc = 16'd0;
        step();
        check("rst_idle_to_wait", {30'd0, rx_en, busy}, 32'd2);
        send(8'h03, 1, 0);
        check("rst_not_in_frame", {30'd0, busy, out_valid}, 32'd0);

        // ---------------- randomized frames vs frame-level model ----------------
        mon_en = 1'b1;
        rand_ready = 1'b1;
        for (int f = 0; f < 80; f++) begin
            kind = int'($urandom_range(0, 9));
            ln = 8'($urandom_range(1, MAXL));
            if (kind == 9) ln = 8'(MAXL);
            pay.delete();
            c = ln;
            for (int i = 0; i < int'(ln); i++) begin
                b = 8'($urandom_range(0, 255));
                pay.push_back(b);
                c = c ^ b;
            end
            if (kind <= 3 || kind >= 8) begin
                send(8'hA5, 1, 0); send(ln, 1, 0);
                for (int i = 0; i < int'(ln); i++) begin
                    exp_q.push_back({(i == int'(ln) - 1), pay[i]});
                    send(pay[i], 1, 0);
                end
                exp_fc++;
                send(c, 1, 0);
            end else if (kind == 4) begin
                send(8'hA5, 1, 0); send(ln, 1, 0);
                for (int i = 0; i < int'(ln); i++) send(pay[i], 1, 0);
                err_q.push_back(2'd2);
                send(c ^ 8'($urandom_range(1, 255)), 1, 0);
            end else if (kind == 5) begin
                send(8'hA5, 1, 0);
                err_q.push_back(2'd1);
                if ($urandom_range(0, 1) == 0) send(8'h00, 1, 0);
                else send(8'($urandom_range(MAXL + 1, 255)), 1, 0);
            end else if (kind == 6) begin
                m = int'($urandom_range(0, int'(ln) + 1));
                send(8'hA5, 1, 0);
                for (int i = 0; i < m; i++) send((i == 0) ? ln : pay[i - 1], 1, 0);
                err_q.push_back(2'd3);
                send(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1);
            end else begin
                for (int i = 0; i < int'($urandom_range(1, 3)); i++) begin
                    case ($urandom_range(0, 2))
                        0: begin
                            b = 8'($urandom_range(0, 255));
                            if (b == 8'hA5) b = 8'h5A;
                            send(b, 1, 0);
                        end
                        1: send(8'h00, 0, 1);
                        default: send(8'hA5, 1, 1);
                    endcase
                end
            end
        end
        n = 0;
        while ((busy || out_valid) && n < 500) begin
            step();
            n++;
        end
        check("rand_final_idle", {30'd0, busy, out_valid}, 32'd0);
        check("rand_out_consumed", 32'(exp_q.size()), 32'd0);
        check("rand_err_consumed", 32'(err_q.size()), 32'd0);
        check("rand_frame_cnt", 32'(frame_cnt), 32'(exp_fc));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
